jump_result_buffer: RTL and testbench

- Sits directly downstream of the jump unit's issue outputs.
- Captures each resolved jump (destination tag, computed target PC, return address) into a small FIFO.
- Drains the FIFO one entry at a time:
  - writes the link value (return address) to the ROB write-back port using a valid/ready handshake;
  - emits a one-cycle fetch-redirect pulse carrying the jump target.
- Decouples the jump unit, which has no stall input, from ROB write-port arbitration.

---
 rtl/jump_result_buffer_pkg.sv | 22 ++
 rtl/jump_result_buffer_sync_fifo_ptr.sv | 81 ++++++++
 rtl/jump_result_buffer.sv | 124 ++++++++++++
 tb/tb_jump_result_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_result_buffer_pkg.sv
// Shared definitions for the functional-unit result buffers: tag constants,
// the jump result record and a PC alignment helper.
package jump_result_buffer_pkg;

    localparam int INST_TAG_WIDTH = 4;
    localparam int COMMON_WIDTH   = 32;

    // All-ones tag marks "no result this cycle" on the issue outputs.
    localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = '1;

    typedef struct packed {
        logic [INST_TAG_WIDTH-1:0] tag;
        logic [COMMON_WIDTH-1:0]   next_pc;
        logic [COMMON_WIDTH-1:0]   ori_pc;
    } jump_result_t;

    // Fetch targets are halfword aligned; bit 0 of a computed target is dropped.
    function automatic logic [COMMON_WIDTH-1:0] align_pc(input logic [COMMON_WIDTH-1:0] pc);
        return {pc[COMMON_WIDTH-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/jump_result_buffer_sync_fifo_ptr.sv
// sync_fifo_ptr: generic single-clock FIFO (storage, wrapping pointers,
// occupancy, full/empty). Flush has priority over push and pop. A push while
// full is accepted only if a pop frees a slot on the same edge.
module sync_fifo_ptr #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [$clog2(DEPTH):0]   o_count_next,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_rdata      = r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign o_count_next = w_count_next;

    // Next occupancy, also used by the parent for registered threshold flags.
    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_do_push && w_do_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Storage write; data cells carry no reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/jump_result_buffer.sv
// jump_result_buffer: queues resolved jumps from the jump unit, writes the
// link value to the ROB with a valid/ready handshake and emits a one-cycle
// fetch redirect per drained entry, in push order.
// Optional feature macro: JUMP_RESULT_BYPASS_EN (empty-FIFO same-cycle bypass).
module jump_result_buffer
    import jump_result_buffer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = INST_TAG_WIDTH,
    parameter int AFULL_TH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TAG_W-1:0]         in_target,
    input  logic [31:0]              in_next_pc,
    input  logic [31:0]              in_ori_pc,
    input  logic                     flush,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     wb_valid,
    output logic [TAG_W-1:0]         wb_tag,
    output logic [31:0]              wb_val,
    input  logic                     wb_ready,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;

    jump_result_t                    w_in_entry;
    jump_result_t                    w_head;
    jump_result_t                    w_out;
    logic [$bits(jump_result_t)-1:0] w_rdata;
    logic [CW-1:0]                   w_count_next;
    logic                            w_fifo_full;
    logic                            w_fifo_empty;
    logic                            w_push_req;
    logic                            w_bypass;
    logic                            w_fire;
    logic                            w_fifo_push;
    logic                            w_fifo_pop;
    logic                            r_redirect_valid;
    logic [31:0]                     r_redirect_pc;
    logic                            r_overflow;
    logic                            r_almost_full;

    // An unknown tag on the issue bus is never treated as a result.
    assign w_push_req = (in_target !== TAG_INVALID) && ((^in_target) !== 1'bx);
    assign w_in_entry = '{tag: in_target, next_pc: in_next_pc, ori_pc: in_ori_pc};
    assign w_head     = jump_result_t'(w_rdata);

`ifdef JUMP_RESULT_BYPASS_EN
    assign w_bypass = w_fifo_empty && w_push_req;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_out    = w_bypass ? w_in_entry : w_head;
    assign wb_valid = !w_fifo_empty || w_bypass;
    assign wb_tag   = wb_valid ? w_out.tag : TAG_INVALID;
    assign wb_val   = wb_valid ? w_out.ori_pc : '0;

    // A bypassed entry that the ROB takes immediately never enters storage.
    assign w_fire      = wb_valid && wb_ready;
    assign w_fifo_pop  = w_fire && !w_fifo_empty;
    assign w_fifo_push = w_push_req && !(w_bypass && wb_ready);

    sync_fifo_ptr #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(jump_result_t))
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst),
        .i_flush      (flush),
        .i_push       (w_fifo_push),
        .i_pop        (w_fifo_pop),
        .i_wdata      (w_in_entry),
        .o_rdata      (w_rdata),
        .o_count      (count),
        .o_count_next (w_count_next),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty)
    );

    // One-cycle redirect pulse for each entry handed to the ROB; flush kills it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else if (flush) begin
            r_redirect_valid <= 1'b0;
        end else if (w_fire) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= align_pc(w_out.next_pc);
        end else begin
            r_redirect_valid <= 1'b0;
        end
    end

    // Sticky overflow: a result was dropped because no slot was free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (!flush && w_fifo_push && w_fifo_full && !w_fifo_pop) begin
            r_overflow <= 1'b1;
        end
    end

    // Back-pressure to dispatch, registered from next-state occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= ((DEPTH - int'(w_count_next)) <= AFULL_TH);
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign overflow       = r_overflow;
    assign almost_full    = r_almost_full;

endmodule

// File: tb/tb_jump_result_buffer.sv
// Self-checking bench for jump_result_buffer: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_jump_result_buffer;
    import jump_result_buffer_pkg::*;

    localparam int DEPTH    = 4;
    localparam int TAG_W    = 4;
    localparam int AFULL_TH = 1;
`ifdef JUMP_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [TAG_W-1:0]  in_target;
    logic [31:0]       in_next_pc;
    logic [31:0]       in_ori_pc;
    logic              flush;
    logic              almost_full;
    logic              overflow;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [31:0]       wb_val;
    logic              wb_ready;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [$clog2(DEPTH):0] count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    jump_result_t q[$];
    bit           m_rv;
    logic [31:0]  m_rpc;
    bit           m_ovf;
    bit           m_af;

    jump_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .AFULL_TH(AFULL_TH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_target      (in_target),
        .in_next_pc     (in_next_pc),
        .in_ori_pc      (in_ori_pc),
        .flush          (flush),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .wb_valid       (wb_valid),
        .wb_tag         (wb_tag),
        .wb_val         (wb_val),
        .wb_ready       (wb_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_rv  = 1'b0;
        m_rpc = '0;
        m_ovf = 1'b0;
        m_af  = 1'b0;
    endtask

    // Compare all outputs against the model for the current state and inputs.
    task automatic compare();
        bit           byp;
        bit           ev;
        jump_result_t e;
        byp = BYP && (q.size() == 0) && (in_target != TAG_INVALID);
        ev  = (q.size() != 0) || byp;
        if (byp) e = '{tag: in_target, next_pc: in_next_pc, ori_pc: in_ori_pc};
        else if (q.size() != 0) e = q[0];
        else e = '{tag: TAG_INVALID, next_pc: '0, ori_pc: '0};
        chk("wb_valid", 64'(wb_valid), 64'(ev));
        chk("wb_tag", 64'(wb_tag), ev ? 64'(e.tag) : 64'(TAG_INVALID));
        chk("wb_val", 64'(wb_val), ev ? 64'(e.ori_pc) : 64'd0);
        chk("count", 64'(count), 64'(q.size()));
        chk("almost_full", 64'(almost_full), 64'(m_af));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
        if (m_rv) chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples.
    task automatic model_step();
        bit           push;
        bit           byp;
        bit           vld;
        bit           fire;
        jump_result_t in_e;
        jump_result_t h;
        if (!rst) begin
            model_clear();
            return;
        end
        in_e = '{tag: in_target, next_pc: in_next_pc, ori_pc: in_ori_pc};
        push = (in_target != TAG_INVALID);
        if (flush) begin
            q.delete();
            m_rv = 1'b0;
        end else begin
            byp  = BYP && (q.size() == 0) && push;
            vld  = (q.size() != 0) || byp;
            fire = vld && wb_ready;
            m_rv = fire;
            if (fire) begin
                if (byp) h = in_e;
                else h = q.pop_front();
                m_rpc = h.next_pc & 32'hFFFF_FFFE;
            end
            if (push && !(byp && fire)) begin
                if (q.size() < DEPTH) q.push_back(in_e);
                else m_ovf = 1'b1;
            end
        end
        m_af = ((DEPTH - q.size()) <= AFULL_TH);
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        #1;
        compare();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        in_target  = TAG_INVALID;
        in_next_pc = '0;
        in_ori_pc  = '0;
        flush      = 1'b0;
    endtask

    task automatic set_in(input logic [TAG_W-1:0] t, input logic [31:0] npc, input logic [31:0] opc);
        in_target  = t;
        in_next_pc = npc;
        in_ori_pc  = opc;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        model_clear();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        wb_ready = 1'b0;
        idle();
        model_clear();
        @(negedge clk);
        do_reset();

        // Reset in the middle of traffic, then no redirect afterwards.
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(4'(i + 1), 32'h1000 + 32'(i * 4), 32'h40 + 32'(i * 4));
            tick();
        end
        wb_ready = 1'b1;
        idle();
        tick();
        do_reset();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_wb_tag", 64'(wb_tag), 64'(TAG_INVALID));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_reset_no_redirect", 64'(redirect_valid), 64'd0);
        end

        // Single push with the ROB ready.
        wb_ready = 1'b1;
        set_in(4'd3, 32'h104, 32'h24);
`ifdef JUMP_RESULT_BYPASS_EN
        #1;
        chk("bypass_wb_valid", 64'(wb_valid), 64'd1);
        chk("bypass_wb_tag", 64'(wb_tag), 64'd3);
        tick();
        idle();
`else
        tick();
        idle();
        chk("single_wb_valid", 64'(wb_valid), 64'd1);
        chk("single_wb_tag", 64'(wb_tag), 64'd3);
        chk("single_wb_val", 64'(wb_val), 64'h24);
        tick();
`endif
        chk("single_redirect_valid", 64'(redirect_valid), 64'd1);
        chk("single_redirect_pc", 64'(redirect_pc), 64'h104);
        tick();
        chk("single_redirect_gone", 64'(redirect_valid), 64'd0);

        // Fill to DEPTH, then one more push is dropped.
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(4'(i + 1), 32'h2000 + 32'(i * 16), 32'h80 + 32'(i * 4));
            tick();
        end
        idle();
        chk("full_count", 64'(count), 64'd4);
        chk("full_almost_full", 64'(almost_full), 64'd1);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_head_tag", 64'(wb_tag), 64'd1);
        wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("drained_count", 64'(count), 64'd0);
        do_reset();

        // Push and pop on the same edge while full.
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(4'(i + 7), 32'h3000 + 32'(i * 8), 32'hC0 + 32'(i * 4));
            tick();
        end
        wb_ready = 1'b1;
        set_in(4'd11, 32'h3100, 32'hF0);
        tick();
        idle();
        wb_ready = 1'b0;
        chk("fullpp_count", 64'(count), 64'd4);
        chk("fullpp_overflow", 64'(overflow), 64'd0);
        chk("fullpp_head_tag", 64'(wb_tag), 64'd8);
        wb_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        // Odd target is aligned.
        set_in(4'd5, 32'h201, 32'h10);
        tick();
        idle();
`ifndef JUMP_RESULT_BYPASS_EN
        tick();
`endif
        chk("align_redirect_pc", 64'(redirect_pc), 64'h200);
        tick();

        // Flush beats a simultaneous push and pop.
        wb_ready = 1'b0;
        set_in(4'd1, 32'h400, 32'h50);
        tick();
        set_in(4'd2, 32'h500, 32'h54);
        tick();
        set_in(4'd12, 32'h600, 32'h58);
        wb_ready = 1'b1;
        flush    = 1'b1;
        tick();
        idle();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_wb_valid", 64'(wb_valid), 64'd0);
        chk("flush_redirect_valid", 64'(redirect_valid), 64'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) < 6)
                    set_in(4'($urandom_range(0, 14)), $urandom, $urandom);
                else
                    set_in(TAG_INVALID, $urandom, $urandom);
                wb_ready = ($urandom_range(0, 1) == 1);
                flush    = ($urandom_range(0, 49) == 0);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
